ibex_rf_wport_arbiter: RTL and testbench

Arbitrates the single write port of the Ibex register file between several writeback requesters, for example ALU/CSR writeback, load writeback and a debug/dummy-instruction path. Arbitration is round-robin with a valid/ready handshake. Each granted write is presented on a registered write port one cycle after acceptance. An optional post-reset clear sequencer walks every architectural register and writes `WordZeroVal` before any requester is served.

---
 rtl/ibex_rf_arb_pkg.sv | 20 ++
 rtl/ibex_rf_wport_arbiter_if.sv | 32 +++
 rtl/ibex_rf_rr_picker.sv | 38 +++
 rtl/ibex_rf_wport_arbiter.sv | 118 +++++++++++
 tb/tb_ibex_rf_wport_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ibex_rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// ibex_rf_arb_pkg: shared types and helpers for the RF write-port arbiter.
// Rev 1.0
// ============================================================================
package ibex_rf_arb_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_arb_state_e;

    localparam int RfAddrW = 5;

    function automatic int rf_num_words(input bit rv32e);
        return rv32e ? 16 : 32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_rf_wport_arbiter_if.sv
`default_nettype none
// ============================================================================
// ibex_rf_wport_arbiter_if: requester bundle and registered RF write port.
// Rev 1.0
// ============================================================================
interface ibex_rf_wport_arbiter_if
    import ibex_rf_arb_pkg::*;
#(
    parameter int NumReq    = 3,
    parameter int DataWidth = 32
);
    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq*RfAddrW-1:0]   req_addr_i;
    logic [NumReq*DataWidth-1:0] req_data_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [RfAddrW-1:0]          waddr_a_o;
    logic [DataWidth-1:0]        wdata_a_o;
    logic                        we_a_o;
    logic                        clear_busy_o;
    logic [2:0]                  grant_idx_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i,
        input  req_ready_o, waddr_a_o, wdata_a_o, we_a_o, clear_busy_o, grant_idx_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i,
        output req_ready_o, waddr_a_o, wdata_a_o, we_a_o, clear_busy_o, grant_idx_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_rf_rr_picker.sv
`default_nettype none
// ============================================================================
// ibex_rf_rr_picker: combinational round-robin picker, search from ptr_i up.
// Rev 1.0
// ============================================================================
module ibex_rf_rr_picker #(
    parameter int NumReq = 3
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [2:0]        ptr_i,
    output logic [NumReq-1:0] grant_o,
    output logic [2:0]        idx_o,
    output logic              any_o
);
    function automatic int wrap_add(input logic [2:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NumReq) s = s - NumReq;
        return s;
    endfunction

    // Outer loop is priority distance from the pointer, so the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!any_o && valid_i[i] && (i == wrap_add(ptr_i, k))) begin
                    grant_o[i] = 1'b1;
                    idx_o      = 3'(i);
                    any_o      = 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ibex_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// ibex_rf_wport_arbiter: round-robin arbiter for the RF write port with an
// optional post-reset clear sequencer (IBEX_RF_CLEAR_EN).  Rev 1.0
// ============================================================================
module ibex_rf_wport_arbiter
    import ibex_rf_arb_pkg::*;
#(
    parameter bit                   RV32E       = 1'b0,
    parameter int                   DataWidth   = 32,
    parameter int                   NumReq      = 3,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ibex_rf_wport_arbiter_if.slave bus
);
`ifdef IBEX_RF_CLEAR_EN
    localparam int                 NumWords = rf_num_words(RV32E);
    localparam logic [RfAddrW-1:0] LastAddr = RfAddrW'(NumWords - 1);
    logic [RfAddrW-1:0]            clr_cnt_q;
`endif

    rf_arb_state_e      state_q;
    logic [2:0]         rr_q;
    logic               we_q;
    logic [RfAddrW-1:0] waddr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [2:0]         grant_idx_q;

    logic [NumReq-1:0]    w_grant;
    logic [2:0]           w_idx;
    logic                 w_any;
    logic                 w_hs;
    logic [2:0]           w_rr_d;
    logic [RfAddrW-1:0]   w_sel_addr;
    logic [RfAddrW-1:0]   w_wr_addr;
    logic [DataWidth-1:0] w_sel_data;

    ibex_rf_rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .valid_i (bus.req_valid_i),
        .ptr_i   (rr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = bus.req_addr_i[i*RfAddrW +: RfAddrW];
                w_sel_data = bus.req_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

    // RV32E has only x0..x15, so address bit 4 is dropped before the write.
    assign w_wr_addr = RV32E ? {1'b0, w_sel_addr[3:0]} : w_sel_addr;
    assign w_hs      = (state_q == RUN) && w_any;
    assign w_rr_d    = (w_idx == 3'(NumReq - 1)) ? 3'd0 : w_idx + 3'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
`ifdef IBEX_RF_CLEAR_EN
            state_q   <= CLEAR;
            clr_cnt_q <= RfAddrW'(1);
`else
            state_q   <= RUN;
`endif
            rr_q        <= 3'd0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            grant_idx_q <= 3'd0;
        end else begin
            case (state_q)
                CLEAR: begin
`ifdef IBEX_RF_CLEAR_EN
                    we_q      <= 1'b1;
                    waddr_q   <= clr_cnt_q;
                    wdata_q   <= WordZeroVal;
                    clr_cnt_q <= clr_cnt_q + RfAddrW'(1);
                    if (clr_cnt_q == LastAddr) state_q <= RUN;
`else
                    we_q    <= 1'b0;
                    state_q <= RUN;
`endif
                end
                RUN: begin
                    // x0 writes are still handshaken but never reach the RF.
                    we_q <= w_hs && (w_wr_addr != '0);
                    if (w_hs) begin
                        rr_q        <= w_rr_d;
                        grant_idx_q <= w_idx;
                        waddr_q     <= w_wr_addr;
                        wdata_q     <= w_sel_data;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready_o = (state_q == RUN) ? w_grant : '0;
    assign bus.waddr_a_o   = waddr_q;
    assign bus.wdata_a_o   = wdata_q;
    assign bus.we_a_o      = we_q;
    assign bus.grant_idx_o = grant_idx_q;
`ifdef IBEX_RF_CLEAR_EN
    assign bus.clear_busy_o = (state_q == CLEAR);
`else
    assign bus.clear_busy_o = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ibex_rf_wport_arbiter: directed + randomized checks against a queue-free
// behavioural model of the arbiter.  Rev 1.0
// ============================================================================
module tb_ibex_rf_wport_arbiter;
`ifdef IBEX_RF_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    localparam int NCLR = 31;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_ne;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    ibex_rf_wport_arbiter_if #(.NumReq(3), .DataWidth(32)) if0 ();
    ibex_rf_wport_arbiter_if #(.NumReq(3), .DataWidth(32)) ife ();

    ibex_rf_wport_arbiter #(.RV32E(1'b0), .DataWidth(32), .NumReq(3), .WordZeroVal(32'h0)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n0),
        .bus    (if0)
    );

    ibex_rf_wport_arbiter #(.RV32E(1'b1), .DataWidth(32), .NumReq(3), .WordZeroVal(32'h0)) u_dut_e (
        .clk_i  (clk),
        .rst_ni (rst_ne),
        .bus    (ife)
    );

    // Reference model state: expected registered outputs and pointer.
    int          m_cyc;
    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [2:0]  m_gidx;

    logic        pv [3];
    logic [4:0]  pa [3];
    logic [31:0] pd [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cyc   = 0;
        m_ptr   = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_gidx  = '0;
    endtask

    // Called at a falling edge: checks registered outputs, drives inputs,
    // checks the grant, advances the model by one clock.
    task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                        output logic [2:0] rdy);
        logic [2:0] er;
        int         g;
        int         c;
        bit         in_clear;
        in_clear = CLR && (m_cyc < NCLR);
        chk("we", 64'(if0.we_a_o), 64'(m_we));
        chk("waddr", 64'(if0.waddr_a_o), 64'(m_waddr));
        chk("wdata", 64'(if0.wdata_a_o), 64'(m_wdata));
        chk("grant_idx", 64'(if0.grant_idx_o), 64'(m_gidx));
        chk("clear_busy", 64'(if0.clear_busy_o), 64'(in_clear));
        if0.req_valid_i = v;
        if0.req_addr_i  = a;
        if0.req_data_i  = d;
        #1;
        er = '0;
        g  = -1;
        if (!in_clear) begin
            for (int k = 0; k < 3; k++) begin
                c = (m_ptr + k) % 3;
                if (g < 0 && v[c]) g = c;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("ready", 64'(if0.req_ready_o), 64'(er));
        rdy = er;
        if (in_clear) begin
            m_we    = 1'b1;
            m_waddr = 5'(m_cyc + 1);
            m_wdata = '0;
        end else if (g >= 0) begin
            m_waddr = a[g*5 +: 5];
            m_wdata = d[g*32 +: 32];
            m_we    = (m_waddr != 5'd0);
            m_gidx  = 3'(g);
            m_ptr   = (g + 1) % 3;
        end else begin
            m_we = 1'b0;
        end
        m_cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  rdy;
        logic [2:0]  v;
        logic [14:0] a;
        logic [95:0] d;

        rst_n0 = 1'b0;
        rst_ne = 1'b0;
        if0.req_valid_i = '0; if0.req_addr_i = '0; if0.req_data_i = '0;
        ife.req_valid_i = '0; ife.req_addr_i = '0; ife.req_data_i = '0;
        for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
        repeat (3) @(negedge clk);

        chk("rst_we", 64'(if0.we_a_o), 64'(1'b0));
        chk("rst_waddr", 64'(if0.waddr_a_o), 64'(5'd0));
        chk("rst_wdata", 64'(if0.wdata_a_o), 64'(32'd0));
        chk("rst_grant_idx", 64'(if0.grant_idx_o), 64'(3'd0));
        chk("rst_busy", 64'(if0.clear_busy_o), 64'(CLR));

        // Run 12 cycles (clear address 12 visible), then reset mid-flight.
        rst_n0 = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++)
            step(3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom}, rdy);
        #2 rst_n0 = 1'b0;
        #1;
        chk("midrst_we", 64'(if0.we_a_o), 64'(1'b0));
        chk("midrst_waddr", 64'(if0.waddr_a_o), 64'(5'd0));
        chk("midrst_grant_idx", 64'(if0.grant_idx_o), 64'(3'd0));
        chk("midrst_busy", 64'(if0.clear_busy_o), 64'(CLR));
        @(negedge clk);
        rst_n0 = 1'b1;
        model_reset();

        if (CLR) begin
            for (int i = 0; i < NCLR; i++)
                step(3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom}, rdy);
        end

        // Fairness: all three requesters valid, addresses 5, 6, 7.
        for (int i = 0; i < 6; i++)
            step(3'b111, {5'd7, 5'd6, 5'd5}, {32'hC7, 32'hB6, 32'hA5}, rdy);
        // Requester 2 alone writes 0xDEADBEEF to x10.
        step(3'b100, {5'd10, 5'd0, 5'd0}, {32'hDEADBEEF, 64'd0}, rdy);
        step(3'b000, 15'd0, 96'd0, rdy);
        // Requester 1 writes x0, then contention shows the pointer at 2.
        step(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h1234, 32'd0}, rdy);
        step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, rdy);
        step(3'b000, 15'd0, 96'd0, rdy);

        // Random traffic; requesters hold until granted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(0, 9) < 6) begin
                    pv[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    pd[i] = $urandom;
                end
                v[i]         = pv[i];
                a[i*5 +: 5]  = pa[i];
                d[i*32 +: 32] = pd[i];
            end
            step(v, a, d, rdy);
            for (int i = 0; i < 3; i++) if (rdy[i]) pv[i] = 1'b0;
        end

        // RV32E instance: clear (if present), then bit 4 of the address is dropped.
        rst_ne = 1'b1;
        if (CLR) begin
            for (int k = 1; k <= 15; k++) begin
                @(negedge clk);
                chk("e_clr_we", 64'(ife.we_a_o), 64'(1'b1));
                chk("e_clr_waddr", 64'(ife.waddr_a_o), 64'(k));
                chk("e_clr_busy", 64'(ife.clear_busy_o), 64'(k < 15));
            end
        end
        ife.req_valid_i = 3'b001;
        ife.req_addr_i  = {5'd0, 5'd0, 5'h13};
        ife.req_data_i  = {64'd0, 32'hCAFE0013};
        #1;
        chk("e_ready0", 64'(ife.req_ready_o), 64'(3'b001));
        @(negedge clk);
        chk("e_we", 64'(ife.we_a_o), 64'(1'b1));
        chk("e_waddr", 64'(ife.waddr_a_o), 64'(5'd3));
        chk("e_wdata", 64'(ife.wdata_a_o), 64'(32'hCAFE0013));
        ife.req_valid_i = 3'b010;
        ife.req_addr_i  = {5'd0, 5'h10, 5'd0};
        ife.req_data_i  = {32'd0, 32'h55, 32'd0};
        #1;
        chk("e_ready1", 64'(ife.req_ready_o), 64'(3'b010));
        @(negedge clk);
        ife.req_valid_i = 3'b000;
        chk("e_x0_we", 64'(ife.we_a_o), 64'(1'b0));
        chk("e_x0_waddr", 64'(ife.waddr_a_o), 64'(5'd0));
        chk("e_grant_idx", 64'(ife.grant_idx_o), 64'(3'd1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
